// File: rtl/mac_pkg.sv
// Shared definitions for the MAC job sequencer.
// Holds the sequencer state encoding and the lane and accumulator geometry
// of the 4-lane signed 8-bit MAC array.
package mac_pkg;

  localparam int LANES      = 4;
  localparam int OP_W       = 8;
  localparam int ACC_W      = 32;
  localparam int LANE_BUS_W = LANES * OP_W;   // packed operand word {l3,l2,l1,l0}
  localparam int ACC_BUS_W  = LANES * ACC_W;  // packed accumulators {o3,o2,o1,o0}

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN1,
    S_DRAIN2,
    S_RESULT
  } state_t;

endpackage

// File: rtl/mac_addr_gen.sv
// Operand address generator for one dot-product job.
// On load it latches the job length and both buffer base addresses and zeroes
// the beat counter. On each step both addresses and the beat counter advance
// by one. Addresses wrap modulo 2^ADDR_W.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   load              latch len_in / a_base / b_base, restart beat count
//   step              advance to the next beat
//   len_in            beats in the job
//   a_base, b_base    buffer start addresses
//   a_addr, b_addr    current read addresses
//   job_len           latched job length
//   last              current beat is the final one (beat == job_len-1)
module mac_addr_gen
  import mac_pkg::*;
#(
  parameter int LEN_W  = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [LEN_W-1:0]  job_len,
  output logic              last
);

  logic [LEN_W-1:0] beat_cnt;

  // NOTE: reset is synchronous (sampled on clk only); every register in this
  // block is updated with <= so all flops see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_addr   <= '0;
      b_addr   <= '0;
      beat_cnt <= '0;
      job_len  <= '0;
    end else if (load) begin
      a_addr   <= a_base;
      b_addr   <= b_base;
      beat_cnt <= '0;
      job_len  <= len_in;
    end else if (step) begin
      a_addr   <= a_addr + ADDR_W'(1);
      b_addr   <= b_addr + ADDR_W'(1);
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  // Only consulted while fetching, which never happens for a zero-length job,
  // so the wrap of job_len-1 at zero is harmless.
  assign last = (beat_cnt == (job_len - LEN_W'(1)));

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the 4-lane signed 8-bit MAC array.
// Accepts a dot-product command, clears the array accumulators for one cycle,
// streams len operand beats from the A/B buffers (one per cycle), waits two
// drain cycles for the array to settle, then captures the accumulators and
// offers them on a valid/ready result port.
// Timeline for a command accepted in cycle T:
//   T+1            CLEAR  (mac_clr_n low)
//   T+2..T+1+len   FETCH  (rd_en high)
//   T+3..T+2+len   mac_start high (read data arrives one cycle after rd_en)
//   T+2+len        DRAIN1
//   T+3+len        DRAIN2 (mac_o captured at the end of this cycle)
//   T+4+len        RESULT (res_valid high until res_ready)
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake (ready only in IDLE)
//   cmd_len, cmd_a_base, cmd_b_base     job length and operand base addresses
//   a_rd_en/a_rd_addr/a_rd_data         A operand buffer (1-cycle read)
//   b_rd_en/b_rd_addr/b_rd_data         B operand buffer (1-cycle read)
//   mac_clr_n                           MAC array reset (low in CLEAR or reset)
//   mac_start, mac_a, mac_b             accumulate strobe and packed operands
//   mac_done, mac_o                     array done flag and accumulators
//   res_valid/res_ready                 result handshake
//   res_data, res_err                   captured accumulators, done-count error
//   busy                                sequencer not idle
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int LEN_W  = 12,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [ADDR_W-1:0]     cmd_a_base,
  input  logic [ADDR_W-1:0]     cmd_b_base,
  output logic                  a_rd_en,
  output logic [ADDR_W-1:0]     a_rd_addr,
  input  logic [LANE_BUS_W-1:0] a_rd_data,
  output logic                  b_rd_en,
  output logic [ADDR_W-1:0]     b_rd_addr,
  input  logic [LANE_BUS_W-1:0] b_rd_data,
  output logic                  mac_clr_n,
  output logic                  mac_start,
  output logic [LANE_BUS_W-1:0] mac_a,
  output logic [LANE_BUS_W-1:0] mac_b,
  input  logic                  mac_done,
  input  logic [ACC_BUS_W-1:0]  mac_o,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_BUS_W-1:0]  res_data,
  output logic                  res_err,
  output logic                  busy
);

  state_t           state_q, state_d;
  logic             accept;
  logic             last_beat;
  logic [LEN_W-1:0] job_len;
  logic             rd_en_q;
  logic [LEN_W:0]   done_cnt, done_cnt_nxt;

  assign accept = (state_q == S_IDLE) && cmd_valid;

  mac_addr_gen #(
    .LEN_W (LEN_W),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (state_q == S_FETCH),
    .len_in (cmd_len),
    .a_base (cmd_a_base),
    .b_base (cmd_b_base),
    .a_addr (a_rd_addr),
    .b_addr (b_rd_addr),
    .job_len(job_len),
    .last   (last_beat)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so every path assigns it;
  // a missing assignment in combinational logic would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_CLEAR;
      S_CLEAR:  state_d = (job_len == '0) ? S_DRAIN1 : S_FETCH;
      S_FETCH:  if (last_beat) state_d = S_DRAIN1;
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_RESULT;
      S_RESULT: if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = rst_n && (state_q == S_IDLE);
  assign mac_clr_n = rst_n && (state_q != S_CLEAR);

  // ------------------------------------------------ operand streaming
  // rd_en is registered from state_d so it is high exactly in FETCH cycles;
  // mac_start trails it by one cycle to line up with the buffer read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en_q   <= 1'b0;
      mac_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rd_en_q   <= (state_d == S_FETCH);
      mac_start <= rd_en_q;
      busy      <= (state_d != S_IDLE);
    end
  end

  assign a_rd_en = rd_en_q;
  assign b_rd_en = rd_en_q;
  assign mac_a   = a_rd_data;
  assign mac_b   = b_rd_data;

  // ------------------------------------------------ done pulse counter
  // Counts cycles with mac_done high since CLEAR, saturating at all ones so a
  // runaway array cannot wrap back to a matching count.
  always_comb begin
    done_cnt_nxt = done_cnt;
    if (mac_done && !(&done_cnt)) done_cnt_nxt = done_cnt + (LEN_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                  done_cnt <= '0;
    else if (state_q == S_CLEAR) done_cnt <= '0;
    else                         done_cnt <= done_cnt_nxt;
  end

  // ------------------------------------------------ result capture
  // The final beat's done pulse lands in DRAIN2, so the error compare uses
  // the count including the current cycle.
  // NOTE: res_data is a plain register, not a memory, so it is reset along
  // with the control flops and never exposes stale data after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else if (state_q == S_DRAIN2) begin
      res_valid <= 1'b1;
      res_data  <= mac_o;
      res_err   <= (done_cnt_nxt != {1'b0, job_len});
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with behavioural operand buffers and a
// behavioural 4-lane signed MAC array.
module tb_mac_seq_ctrl;

  localparam int LEN_W  = 12;
  localparam int ADDR_W = 10;

  logic               clk, rst_n;
  logic               cmd_valid, cmd_ready;
  logic [LEN_W-1:0]   cmd_len;
  logic [ADDR_W-1:0]  cmd_a_base, cmd_b_base;
  logic               a_rd_en, b_rd_en;
  logic [ADDR_W-1:0]  a_rd_addr, b_rd_addr;
  logic [31:0]        a_rd_data, b_rd_data;
  logic               mac_clr_n, mac_start, mac_done;
  logic [31:0]        mac_a, mac_b;
  logic [127:0]       mac_o;
  logic               res_valid, res_ready, res_err, busy;
  logic [127:0]       res_data;

  mac_seq_ctrl #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .mac_clr_n(mac_clr_n), .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b),
    .mac_done(mac_done), .mac_o(mac_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------- operand buffers
  logic [31:0] a_mem [1024];
  logic [31:0] b_mem [1024];

  initial begin
    a_rd_data = '0;
    b_rd_data = '0;
  end

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  end

  // ---------------------------------------------- MAC array model
  logic [127:0] acc = '0;
  int           beat = 0;
  bit           drop_req = 0;   // suppress the done pulse of beat 2
  assign mac_o = acc;

  initial mac_done = 1'b0;

  always @(posedge clk) begin
    if (!mac_clr_n) begin
      acc      <= '0;
      mac_done <= 1'b0;
      beat     <= 0;
    end else if (mac_start) begin
      for (int l = 0; l < 4; l++) begin
        logic signed [15:0] p;
        p = $signed(mac_a[8*l +: 8]) * $signed(mac_b[8*l +: 8]);
        acc[32*l +: 32] <= acc[32*l +: 32] + {{16{p[15]}}, p};
      end
      mac_done <= !(drop_req && beat == 2);
      beat     <= beat + 1;
    end else begin
      mac_done <= 1'b0;
    end
  end

  // ---------------------------------------------- activity monitor
  int                rd_total = 0, start_total = 0, clr_low = 0;
  logic [ADDR_W-1:0] a_log [256];
  logic [ADDR_W-1:0] b_log [256];

  always @(negedge clk) begin
    if (a_rd_en) begin
      a_log[rd_total % 256] = a_rd_addr;
      b_log[rd_total % 256] = b_rd_addr;
      rd_total++;
    end
    if (mac_start) start_total++;
    if (rst_n && !mac_clr_n) clr_low++;
  end

  // ---------------------------------------------- scoreboard
  logic [127:0] exp_data [16];
  logic         exp_err  [16];
  int           exp_lat  [16];
  int           exp_acc  [16];
  string        exp_name [16];
  int           n_push = 0;
  int           n_pop  = 0;

  bit           seen = 0;
  int           rise_cyc;
  logic [127:0] held_data;
  logic         held_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (res_valid) begin
      if (!seen) begin
        seen      = 1;
        rise_cyc  = cyc;
        held_data = res_data;
        held_err  = res_err;
      end else begin
        check("res_data_stable", res_data, held_data);
        check("res_err_stable", res_err, held_err);
      end
      if (res_ready) begin
        if (n_pop == n_push) begin
          check("unexpected_result", res_valid, 1'b0);
        end else begin
          check({exp_name[n_pop % 16], "_data"}, res_data, exp_data[n_pop % 16]);
          check({exp_name[n_pop % 16], "_err"}, res_err, exp_err[n_pop % 16]);
          check({exp_name[n_pop % 16], "_latency"}, rise_cyc - exp_acc[n_pop % 16],
                exp_lat[n_pop % 16]);
          n_pop++;
        end
        seen = 0;
      end
    end
  end

  // ---------------------------------------------- stimulus helpers
  task automatic send(input string name, input int len, input int ab, input int bb,
                      input logic [127:0] data, input logic err, input bit expect_res);
    int waited = 0;
    @(posedge clk); #1;
    cmd_len    = LEN_W'(len);
    cmd_a_base = ADDR_W'(ab);
    cmd_b_base = ADDR_W'(bb);
    cmd_valid  = 1'b1;
    @(negedge clk);
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_accept"}, cmd_ready, 1'b1);
    if (cmd_ready && expect_res) begin
      exp_name[n_push % 16] = name;
      exp_data[n_push % 16] = data;
      exp_err [n_push % 16] = err;
      exp_lat [n_push % 16] = len + 4;
      exp_acc [n_push % 16] = cyc;
      n_push++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_results(input string name);
    int waited = 0;
    while (n_pop != n_push && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_results_drained"}, n_pop, n_push);
  endtask

  // ---------------------------------------------- directed sequence
  int rd0, st0, clr0, w;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
    cmd_a_base = '0; cmd_b_base = '0; res_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      a_mem[i]       = {4{8'(i + 1)}};
      b_mem[100 + i] = {4{8'd2}};
    end
    for (int i = 0; i < 3; i++) begin
      a_mem[200 + i] = 32'h00FF_7F80;   // lanes {0,-1,127,-128}
      b_mem[300 + i] = 32'h05FF_8080;   // lanes {5,-1,-128,-128}
    end
    a_mem[1022] = 32'h0101_0101;
    a_mem[1023] = 32'h0101_0101;
    for (int i = 0; i < 4; i++) b_mem[500 + i] = {4{8'd3}};
    for (int i = 0; i < 5; i++) begin
      a_mem[10 + i] = 32'h0101_0101;
      b_mem[10 + i] = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < 2; i++) begin
      a_mem[20 + i] = 32'h0303_0303;
      b_mem[20 + i] = 32'h0404_0404;
    end

    // Reset behaviour
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_mac_clr_n", mac_clr_n, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_res_valid", res_valid, 1'b0);
    check("post_rst_rd_en", a_rd_en, 1'b0);
    check("post_rst_mac_start", mac_start, 1'b0);
    check("post_rst_res_data", res_data, 128'd0);

    // Job 1: basic accumulate, 20 per lane
    rd0 = rd_total; st0 = start_total;
    send("j1", 4, 0, 100, {4{32'd20}}, 1'b0, 1'b1);
    wait_results("j1");
    check("j1_reads", rd_total - rd0, 4);
    check("j1_starts", start_total - st0, 4);
    check("j1_b_addr_first", b_log[rd0 % 256], 10'd100);

    // Job 2: signed extremes per lane
    clr0 = clr_low; st0 = start_total;
    send("j2", 3, 200, 300, {32'd0, 32'd3, 32'hFFFF_4180, 32'h0000_C000}, 1'b0, 1'b1);
    wait_results("j2");
    check("j2_clr_cycles", clr_low - clr0, 1);
    check("j2_starts", start_total - st0, 3);

    // Job 3: zero-length job
    rd0 = rd_total; st0 = start_total;
    send("j3", 0, 50, 50, 128'd0, 1'b0, 1'b1);
    wait_results("j3");
    check("j3_reads", rd_total - rd0, 0);
    check("j3_starts", start_total - st0, 0);

    // Job 4: address wrap and back-pressure on the result port
    @(posedge clk); #1;
    res_ready = 1'b0;
    rd0 = rd_total;
    send("j4", 4, 1022, 500, {4{32'd15}}, 1'b0, 1'b1);
    w = 0;
    while (!res_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("j4_res_valid_seen", res_valid, 1'b1);
    check("j4_busy_in_result", busy, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("j4_cmd_ready_held", cmd_ready, 1'b0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_results("j4");
    check("j4_a_addr0", a_log[(rd0 + 0) % 256], 10'd1022);
    check("j4_a_addr1", a_log[(rd0 + 1) % 256], 10'd1023);
    check("j4_a_addr2", a_log[(rd0 + 2) % 256], 10'd0);
    check("j4_a_addr3", a_log[(rd0 + 3) % 256], 10'd1);
    check("j4_b_addr3", b_log[(rd0 + 3) % 256], 10'd503);

    // Jobs 5/6: missing done pulse, then an independent back-to-back job
    drop_req = 1;
    send("j5", 5, 10, 10, {4{32'hFFFF_FFFB}}, 1'b1, 1'b1);
    send("j6", 2, 20, 20, {4{32'd24}}, 1'b0, 1'b1);
    drop_req = 0;
    wait_results("j6");

    // Job 7: reset pulse mid-fetch drops the job
    send("j7", 8, 30, 30, 128'd0, 1'b0, 1'b0);
    w = 0;
    while (!a_rd_en && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("j7_fetching", a_rd_en, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("j7_clr_n_in_reset", mac_clr_n, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("j7_cmd_ready", cmd_ready, 1'b1);
    check("j7_res_valid", res_valid, 1'b0);
    check("j7_rd_en", a_rd_en, 1'b0);
    check("j7_mac_start", mac_start, 1'b0);
    check("j7_busy", busy, 1'b0);
    rd0 = rd_total; st0 = start_total;
    repeat (12) @(negedge clk);
    check("j7_no_more_reads", rd_total - rd0, 0);
    check("j7_no_more_starts", start_total - st0, 0);
    check("j7_no_result", res_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
